// File: rtl/ora_misr.sv
// rtl/ora_misr.sv - LBIST output response analyzer: MISR compaction with golden-signature compare
module ora_misr #(
    parameter int OUTPUT_BITS  = 4,
    parameter int SIG_BITS     = 8,
    parameter int NUM_PATTERNS = 200,
    parameter logic [SIG_BITS-1:0] POLY = SIG_BITS'('h1D),
    parameter logic [SIG_BITS-1:0] SEED = '0,
    localparam int CNT_BITS = $clog2(NUM_PATTERNS + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   abort,
    input  logic                   resp_valid,
    input  logic [OUTPUT_BITS-1:0] resp,
    input  logic [SIG_BITS-1:0]    golden_sig,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic                   overrun,
    output logic [SIG_BITS-1:0]    signature,
    output logic [CNT_BITS-1:0]    count
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPACT = 2'd1,
        COMPARE = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t state;
    state_t state_next;

    logic                session_start;
    logic                abort_active;
    logic                compact_en;
    logic                last_word;
    logic [SIG_BITS-1:0] misr_next;

    // A new session may only be opened from IDLE or DONE; abort outranks start.
    assign session_start = start && !abort && (state == IDLE || state == DONE);
    assign abort_active  = abort && (state != IDLE);
    assign compact_en    = (state == COMPACT) && !abort && resp_valid;
    assign last_word     = (count == CNT_BITS'(NUM_PATTERNS - 1));

    // Shift left, fold the bit falling off the top back in through the taps, then mix in the response.
    assign misr_next = {signature[SIG_BITS-2:0], 1'b0}
                     ^ (signature[SIG_BITS-1] ? POLY : '0)
                     ^ SIG_BITS'(resp);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode with priority abort > start > resp_valid.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (!abort && start) state_next = COMPACT;
            end
            COMPACT: begin
                if (abort)                        state_next = IDLE;
                else if (resp_valid && last_word) state_next = COMPARE;
            end
            COMPARE: begin
                state_next = abort ? IDLE : DONE;
            end
            DONE: begin
                if (abort)      state_next = IDLE;
                else if (start) state_next = COMPACT;
            end
            default: state_next = IDLE;
        endcase
    end

    // Registered status flags follow the state being entered so they line up with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= (state_next == COMPACT) || (state_next == COMPARE);
            done <= (state_next == DONE);
        end
    end

    // MISR, word counter, verdict and overrun; abort leaves signature/count intact for debug.
    always_ff @(posedge clk) begin
        if (rst) begin
            signature <= SEED;
            count     <= '0;
            pass      <= 1'b0;
            overrun   <= 1'b0;
        end else if (abort_active) begin
            pass <= 1'b0;
        end else if (session_start) begin
            signature <= SEED;
            count     <= '0;
            pass      <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (compact_en) begin
                signature <= misr_next;
                count     <= count + CNT_BITS'(1);
            end
            if (state == COMPARE) begin
                pass <= (signature == golden_sig);
            end
            if (resp_valid && (state == COMPARE || state == DONE)) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ora_misr.sv
// tb/tb_ora_misr.sv - randomized and directed self-checking bench for ora_misr against a session-level model
module tb_ora_misr;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       resp_valid = 1'b0;
    logic [3:0] resp = '0;
    logic [7:0] golden_sig = '0;

    logic       busy_o [3];
    logic       done_o [3];
    logic       pass_o [3];
    logic       ovr_o  [3];
    logic [7:0] sig_o  [3];
    logic [1:0] cnt2;
    logic [3:0] cnt9;
    logic [7:0] cnt200;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ora_misr #(.NUM_PATTERNS(2)) u_p2 (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .resp_valid(resp_valid),
        .resp(resp), .golden_sig(golden_sig), .busy(busy_o[0]), .done(done_o[0]),
        .pass(pass_o[0]), .overrun(ovr_o[0]), .signature(sig_o[0]), .count(cnt2)
    );
    ora_misr #(.NUM_PATTERNS(9)) u_p9 (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .resp_valid(resp_valid),
        .resp(resp), .golden_sig(golden_sig), .busy(busy_o[1]), .done(done_o[1]),
        .pass(pass_o[1]), .overrun(ovr_o[1]), .signature(sig_o[1]), .count(cnt9)
    );
    ora_misr u_p200 (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .resp_valid(resp_valid),
        .resp(resp), .golden_sig(golden_sig), .busy(busy_o[2]), .done(done_o[2]),
        .pass(pass_o[2]), .overrun(ovr_o[2]), .signature(sig_o[2]), .count(cnt200)
    );

    // Session model: phase 0=idle 1=collecting 2=judging 3=finished.
    int         np    [3] = '{2, 9, 200};
    int         m_ph  [3] = '{0, 0, 0};
    logic [7:0] m_sig [3] = '{8'h00, 8'h00, 8'h00};
    int         m_cnt [3] = '{0, 0, 0};
    logic       m_pass[3] = '{1'b0, 1'b0, 1'b0};
    logic       m_ovr [3] = '{1'b0, 1'b0, 1'b0};

    // Multiply the signature polynomial by x modulo x^8+x^4+x^3+x^2+1, then add the response.
    function automatic logic [7:0] gf_step(input logic [7:0] s, input logic [3:0] r);
        logic [8:0] t;
        t = {s, 1'b0};
        if (t[8]) t = t ^ 9'h11D;
        return t[7:0] ^ {4'h0, r};
    endfunction

    function automatic int count_of(input int k);
        if (k == 0) return int'(cnt2);
        if (k == 1) return int'(cnt9);
        return int'(cnt200);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge(input int k);
        if (rst) begin
            m_ph[k] = 0; m_sig[k] = 8'h00; m_cnt[k] = 0; m_pass[k] = 1'b0; m_ovr[k] = 1'b0;
        end else if (m_ph[k] != 0 && abort) begin
            m_ph[k] = 0; m_pass[k] = 1'b0;
        end else if ((m_ph[k] == 0 || m_ph[k] == 3) && start && !abort) begin
            m_ph[k] = 1; m_sig[k] = 8'h00; m_cnt[k] = 0; m_pass[k] = 1'b0; m_ovr[k] = 1'b0;
        end else if (m_ph[k] == 1) begin
            if (resp_valid) begin
                m_sig[k] = gf_step(m_sig[k], resp);
                m_cnt[k] = m_cnt[k] + 1;
                if (m_cnt[k] == np[k]) m_ph[k] = 2;
            end
        end else if (m_ph[k] == 2) begin
            m_pass[k] = (m_sig[k] == golden_sig);
            if (resp_valid) m_ovr[k] = 1'b1;
            m_ph[k] = 3;
        end else if (m_ph[k] == 3) begin
            if (resp_valid) m_ovr[k] = 1'b1;
        end
    endtask

    // Advance the model on each edge and compare every output of every instance just after it.
    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) model_edge(k);
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("cmp%0d_busy", k), int'(busy_o[k]), int'(m_ph[k] == 1 || m_ph[k] == 2));
            chk($sformatf("cmp%0d_done", k), int'(done_o[k]), int'(m_ph[k] == 3));
            chk($sformatf("cmp%0d_pass", k), int'(pass_o[k]), int'(m_pass[k]));
            chk($sformatf("cmp%0d_overrun", k), int'(ovr_o[k]), int'(m_ovr[k]));
            chk($sformatf("cmp%0d_signature", k), int'(sig_o[k]), int'(m_sig[k]));
            chk($sformatf("cmp%0d_count", k), count_of(k), m_cnt[k]);
        end
    end

    task automatic step(input logic s, input logic a, input logic v, input logic [3:0] r);
        start = s; abort = a; resp_valid = v; resp = r;
        @(posedge clk);
        #2;
    endtask

    initial begin
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        chk("reset_sig", int'(sig_o[1]), 'h00);
        chk("reset_cnt", int'(cnt9), 0);
        chk("reset_flags", {busy_o[1], done_o[1], pass_o[1], ovr_o[1]}, 0);
        rst = 1'b0;

        // Two-word session, matching golden.
        golden_sig = 8'h1F;
        step(1, 0, 0, 0);
        step(0, 0, 1, 4'hF);
        chk("p2_word1_sig", int'(sig_o[0]), 'h0F);
        step(0, 0, 1, 4'h1);
        chk("p2_word2_sig", int'(sig_o[0]), 'h1F);
        chk("p2_compare_done", int'(done_o[0]), 0);
        step(0, 0, 0, 0);
        chk("p2_done", int'(done_o[0]), 1);
        chk("p2_pass", int'(pass_o[0]), 1);
        chk("model_p2_sig", int'(m_sig[0]), 'h1F);

        // Same stream, wrong golden; then overrun and restart from DONE.
        golden_sig = 8'h1E;
        step(0, 1, 0, 0);
        step(1, 0, 0, 0);
        step(0, 0, 1, 4'hF);
        step(0, 0, 1, 4'h1);
        step(0, 0, 0, 0);
        chk("p2_fail_done", int'(done_o[0]), 1);
        chk("p2_fail_pass", int'(pass_o[0]), 0);
        step(0, 0, 1, 4'h5);
        chk("p2_overrun", int'(ovr_o[0]), 1);
        chk("p2_overrun_sig", int'(sig_o[0]), 'h1F);
        step(1, 0, 0, 0);
        chk("p2_restart", {busy_o[0], done_o[0], ovr_o[0]}, 3'b100);
        chk("p2_restart_cnt", int'(cnt2), 0);

        // Feedback wrap, back-to-back words.
        golden_sig = 8'h1D;
        step(0, 1, 0, 0);
        step(1, 0, 0, 0);
        for (int i = 0; i < 9; i++) begin
            step(0, 0, 1, (i == 0) ? 4'h1 : 4'h0);
            if (i == 7) chk("p9_word8_sig", int'(sig_o[1]), 'h80);
        end
        chk("p9_word9_sig", int'(sig_o[1]), 'h1D);
        chk("p9_count", int'(cnt9), 9);
        chk("model_wrap", int'(m_sig[1]), 'h1D);
        step(0, 0, 0, 0);
        chk("p9_pass", int'(pass_o[1]) + 2 * int'(done_o[1]), 3);

        // Same stream with random gaps; start pulses inside the session are ignored.
        step(0, 1, 0, 0);
        step(1, 0, 0, 0);
        for (int i = 0; i < 9; i++) begin
            repeat ($urandom_range(0, 3)) begin
                step(i == 4, 0, 0, 4'($urandom));
                chk("p9_gap_busy", int'(busy_o[1]), 1);
                chk("p9_gap_cnt", int'(cnt9), i);
            end
            step(0, 0, 1, (i == 0) ? 4'h1 : 4'h0);
        end
        chk("p9_gap_sig", int'(sig_o[1]), 'h1D);
        step(0, 0, 0, 0);
        chk("p9_gap_pass", int'(pass_o[1]), 1);

        // Abort after four words, then reset mid-session, then a clean start.
        step(0, 1, 0, 0);
        step(1, 0, 0, 0);
        repeat (4) step(0, 0, 1, 4'($urandom));
        step(0, 1, 0, 0);
        chk("p9_abort_flags", {busy_o[1], done_o[1]}, 0);
        chk("p9_abort_cnt", int'(cnt9), 4);
        step(1, 0, 0, 0);
        step(0, 0, 1, 4'h7);
        step(0, 0, 1, 4'h3);
        rst = 1'b1;
        step(0, 0, 1, 4'h9);
        rst = 1'b0;
        chk("p9_rst_sig", int'(sig_o[1]), 0);
        chk("p9_rst_flags", {busy_o[1], done_o[1], pass_o[1], ovr_o[1]}, 0);
        chk("p9_rst_cnt", int'(cnt9), 0);
        step(1, 0, 0, 0);
        chk("p9_start_after_rst", int'(busy_o[1]) * 256 + int'(sig_o[1]), 256);

        // Full default-length session of zero responses.
        golden_sig = 8'h00;
        step(0, 1, 0, 0);
        step(1, 0, 0, 0);
        repeat (200) step(0, 0, 1, 4'h0);
        chk("p200_count", int'(cnt200), 200);
        chk("p200_not_done_yet", int'(done_o[2]), 0);
        step(0, 0, 0, 0);
        chk("p200_done", int'(done_o[2]), 1);
        chk("p200_pass", int'(pass_o[2]), 1);

        // Random traffic; golden sometimes tracks the short session so both verdicts occur.
        for (int i = 0; i < 4000; i++) begin
            rst = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 3) == 0) golden_sig = m_sig[$urandom_range(0, 1)];
            else if ($urandom_range(0, 7) == 0) golden_sig = 8'($urandom);
            step($urandom_range(0, 9) == 0, $urandom_range(0, 59) == 0,
                 $urandom_range(0, 3) != 0, 4'($urandom));
        end
        rst = 1'b0;
        step(0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
